// File: rtl/tc_sram_xbar.sv
// tc_sram_xbar: banked operand SRAM with one strobed write port and two arbitrated read ports.
// Write-first forwarding, in-order read pipeline of 1 or 2 cycles, saturating conflict counter.
module tc_sram_xbar #(
  parameter int NumWords    = 1024,
  parameter int NumBanks    = 4,
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1,
  parameter int AddrWidth   = $clog2(NumWords),
  parameter int CntWidth    = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   we,
  input  logic [AddrWidth-1:0]   waddr,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [DataWidth/8-1:0] wstrb,
  input  logic                   ra_valid,
  output logic                   ra_ready,
  input  logic [AddrWidth-1:0]   ra_addr,
  output logic                   ra_rvalid,
  output logic [DataWidth-1:0]   ra_rdata,
  input  logic                   rb_valid,
  output logic                   rb_ready,
  input  logic [AddrWidth-1:0]   rb_addr,
  output logic                   rb_rvalid,
  output logic [DataWidth-1:0]   rb_rdata,
  output logic [CntWidth-1:0]    conflict_cnt
);
  localparam int BankBits  = $clog2(NumBanks);
  localparam int Rows      = NumWords / NumBanks;
  localparam int StrbWidth = DataWidth / 8;

  if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
    $error("tc_sram_xbar: ReadLatency must be 1 or 2");
  end
  if (NumBanks < 2 || (NumBanks & (NumBanks - 1)) != 0) begin : g_bad_banks
    $error("tc_sram_xbar: NumBanks must be a power of 2 and at least 2");
  end
  if ((NumWords & (NumWords - 1)) != 0 || NumWords < NumBanks || DataWidth % 8 != 0) begin : g_bad_geom
    $error("tc_sram_xbar: illegal NumWords/DataWidth");
  end

  logic [DataWidth-1:0] mem_q [NumBanks][Rows];
  logic [1:0][AddrWidth-1:0] raddr;
  logic [1:0][DataWidth-1:0] rd_word, pd, rd_q;
  logic [1:0] acc, pv, rv_q;
  logic conflict, prio_q, prio_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign raddr = {rb_addr, ra_addr};

  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < StrbWidth; i++)
        if (wstrb[i]) mem_q[waddr[BankBits-1:0]][waddr[AddrWidth-1:BankBits]][8*i +: 8] <= wdata[8*i +: 8];
  end

  // A read that hits the word being written this cycle sees the strobed merge.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = mem_q[raddr[p][BankBits-1:0]][raddr[p][AddrWidth-1:BankBits]];
      for (int i = 0; i < StrbWidth; i++)
        if (we && wstrb[i] && waddr == raddr[p]) rd_word[p][8*i +: 8] = wdata[8*i +: 8];
    end
  end

  assign conflict = ra_valid & rb_valid
                  & (ra_addr[BankBits-1:0] == rb_addr[BankBits-1:0])
                  & (ra_addr[AddrWidth-1:BankBits] != rb_addr[AddrWidth-1:BankBits]);
  assign ra_ready = ra_valid & (~conflict | ~prio_q);
  assign rb_ready = rb_valid & (~conflict | prio_q);
  assign acc      = {rb_ready, ra_ready};

  always_comb begin
    prio_d = conflict ? ~prio_q : prio_q;
    cnt_d  = (conflict && cnt_q != {CntWidth{1'b1}}) ? cnt_q + CntWidth'(1) : cnt_q;
  end

  if (ReadLatency == 2) begin : g_lat2
    logic [1:0] s1_v_q;
    logic [1:0][DataWidth-1:0] s1_d_q;
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        s1_v_q <= '0;
        s1_d_q <= '0;
      end else begin
        s1_v_q <= acc;
        s1_d_q <= rd_word;
      end
    end
    assign pv = s1_v_q;
    assign pd = s1_d_q;
  end else begin : g_lat1
    assign pv = acc;
    assign pd = rd_word;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rv_q   <= '0;
      rd_q   <= '0;
      prio_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rv_q   <= pv;
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
      for (int p = 0; p < 2; p++)
        if (pv[p]) rd_q[p] <= pd[p];
    end
  end

  assign ra_rvalid    = rv_q[0];
  assign rb_rvalid    = rv_q[1];
  assign ra_rdata     = rd_q[0];
  assign rb_rdata     = rd_q[1];
  assign conflict_cnt = cnt_q;
endmodule

// File: doc/tc_sram_xbar.md
Name: tc_sram_xbar

Overview:
- Parametrised multi-bank tensor-core operand SRAM: one write port and two read ports (A, B) over a single flat word address space.
- Addresses are word-interleaved across NumBanks banks; each bank does one read and one write per cycle.
- Read ports use valid/ready handshakes, with bank-conflict arbitration, a configurable read pipeline, byte-strobed writes, write-to-read forwarding and a saturating conflict counter.
- Sits between the tensor-core operand fetch / writeback units and the storage array.

Parameters:
- NumWords, 1024, total words; power of 2, >= NumBanks.
- NumBanks, 4, bank count; power of 2, >= 2.
- DataWidth, 32, word width; multiple of 8.
- ReadLatency, 1, cycles from accepted read to rvalid; legal values 1 or 2.
- AddrWidth, $clog2(NumWords), flat word address width (derived).
- CntWidth, 16, conflict counter width.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous reset, active low.
- we  in  1  write request; always accepted.
- waddr  in  AddrWidth  write word address.
- wdata  in  DataWidth  write data.
- wstrb  in  DataWidth/8  byte enables.
- ra_valid  in  1  port A read request.
- ra_ready  out  1  port A request accepted this cycle.
- ra_addr  in  AddrWidth  port A address.
- ra_rvalid  out  1  port A data valid.
- ra_rdata  out  DataWidth  port A read data.
- rb_valid, rb_ready, rb_addr, rb_rvalid, rb_rdata: same as port A, for port B.
- conflict_cnt  out  CntWidth  saturating count of conflict stalls.

Behaviour:
- Address mapping: bank = addr[log2(NumBanks)-1:0]; row = addr[AddrWidth-1:log2(NumBanks)].
- Reset (nrst low, async): ra/rb_rvalid=0, ra/rb_rdata=0, conflict_cnt=0, prio=A, read pipeline flushed. Array contents are not reset.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced for them. Post-reset reads of previously written words are undefined.
- ready is combinational from the current-cycle valids and addresses:
  - No conflict: both banks differ, or same bank and same row (broadcast, both served) → ready=1 on each valid port.
  - Conflict: both valid, same bank, different row → only the port named by prio gets ready=1. prio then flips to the other port; the loser holds valid and address.
  - prio changes only on a conflict cycle.
  - ready=0 whenever the port's valid=0.
- Accepted read: handshake is valid&ready. rvalid pulses exactly ReadLatency cycles later with that read's data. Accepted reads are fully pipelined, one per port per cycle, and results return in order.
- rdata holds its last value while rvalid=0.
- Write: on a clk edge with we=1, each byte i with wstrb[i]=1 is written to (bank,row); bytes with wstrb[i]=0 are unchanged. wstrb=0 is a no-op.
- Same-cycle write and read to the same address: the read returns the post-write word, merged per strobe (write-first forwarding). This holds for both ports simultaneously.
- Reads accepted after a write see that write.
- conflict_cnt increments by 1 on each conflict cycle and saturates at 2^CntWidth-1 (no wrap).
- ReadLatency=2 adds one output register stage. Forwarding semantics are unchanged.
- Illegal ReadLatency or non-power-of-2 NumBanks: elaboration error via a static check.

Test Plan:
- Reset, then idle → rvalid both 0, rdata 0, conflict_cnt 0. Assert nrst mid-burst with 3 reads in flight → no rvalid follows.
- Write 0xDEADBEEF @5 with strobe 0xF, then 0x000000AA @5 with strobe 0x1; read A @5 → ra_rdata=0xDEADBEAA, ra_rvalid exactly ReadLatency cycles after handshake.
- Same cycle: write 0x12345678 @8, A reads @8, B reads @9 → A returns 0x12345678 (forwarded). B returns the @9 contents, both ready=1.
- Conflict, 4 banks: A @0, B @4, both held valid → cycle 0 A ready, B not. Cycle 1 B ready. conflict_cnt=1. Data correct for each.
- Broadcast: A and B both @12 → both ready in one cycle, identical data, conflict_cnt unchanged.
- Stream 100 back-to-back non-conflicting reads per port at ReadLatency=2 → 100 rvalids per port, in order, throughput 1/cycle. With CntWidth=4, 20 forced conflicts → conflict_cnt=15.
